pmp_csr_regfile: RTL

- Machine-mode CSR writer and storage for the physical-memory-protection entries: pmpcfg0..3 (0x3A0–0x3A3) and pmpaddr0..15 (0x3B0–0x3BF), RV32.
- Presents registered per-entry cfg, address and precomputed NAPOT mask to the combinational PMP permission checker.
- Enforces lock and WARL rules, so the checker never sees an illegal encoding.
- Sits beside the CSR file; driven by the core's CSR write/read strobes.

---
 rtl/pmp_pkg.sv | 46 ++++
 rtl/pmp_entry.sv | 51 +++++
 rtl/pmp_csr_regfile.sv | 108 ++++++++++
 3 files changed

// File: rtl/pmp_pkg.sv
// Shared PMP definitions: CSR bases, A-field encodings, cfg layout and helpers.
package pmp_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned PMP_AW = 30;

    localparam logic [11:0] PMPCFG_BASE  = 12'h3A0;
    localparam logic [11:0] PMPADDR_BASE = 12'h3B0;

    typedef enum logic [1:0] {
        A_OFF   = 2'd0,
        A_TOR   = 2'd1,
        A_NA4   = 2'd2,
        A_NAPOT = 2'd3
    } pmp_a_e;

    typedef struct packed {
        logic       l;
        logic [1:0] rsv;
        pmp_a_e     a;
        logic       x;
        logic       w;
        logic       r;
    } pmp_cfg_t;

    // Turn a raw cfg byte into the legal encoding the checker may see.
    function automatic pmp_cfg_t pmp_cfg_legalize(input logic [7:0] wd);
        pmp_cfg_t c;
        c.l   = wd[7];
        c.rsv = 2'b00;
        c.a   = pmp_a_e'(wd[4:3]);
        c.x   = wd[2];
        c.w   = wd[1] & wd[0];
        c.r   = wd[0];
        return c;
    endfunction

    // NAPOT byte mask: trailing ones of {addr, a0} open up the low mask bits.
    function automatic logic [XLEN-1:0] pmp_napot_mask(input logic [PMP_AW-1:0] addr,
                                                       input logic              a0);
        logic [PMP_AW-1:0] x;
        x = (addr << 1) | PMP_AW'(a0);
        return {x & ~(x + PMP_AW'(1)), 2'b11};
    endfunction

endpackage

// File: rtl/pmp_entry.sv
// One PMP entry: cfg/addr/mask registers with lock gating and WARL legalisation.
module pmp_entry
    import pmp_pkg::*;
#(
    parameter int unsigned PADDR_BITS = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              cfg_we,
    input  logic [7:0]        cfg_wdata,
    input  logic              addr_we,
    input  logic [PMP_AW-1:0] addr_wdata,
    input  logic              next_tor_lock,
    output pmp_cfg_t          cfg,
    output logic [PMP_AW-1:0] addr,
    output logic [XLEN-1:0]   mask,
    output logic              changed_c
);

    localparam int unsigned AW = PADDR_BITS - 2;

    pmp_cfg_t          cfg_nxt;
    logic [PMP_AW-1:0] addr_nxt;

    // Next state after lock gating; a locked TOR successor also freezes this address.
    always_comb begin
        cfg_nxt  = cfg;
        addr_nxt = addr;
        if (cfg_we && !cfg.l) begin
            cfg_nxt = pmp_cfg_legalize(cfg_wdata);
        end
        if (addr_we && !cfg.l && !next_tor_lock) begin
            addr_nxt = PMP_AW'(addr_wdata[AW-1:0]);
        end
        changed_c = (cfg_nxt != cfg) || (addr_nxt != addr);
    end

    // State registers; the mask tracks the same edge as addr/cfg.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cfg  <= '0;
            addr <= '0;
            mask <= XLEN'(32'h3);
        end else begin
            cfg  <= cfg_nxt;
            addr <= addr_nxt;
            mask <= pmp_napot_mask(addr_nxt, cfg_nxt.a[0]);
        end
    end

endmodule

// File: rtl/pmp_csr_regfile.sv
// PMP CSR storage: address decode, per-entry instances, readback and update pulse.
module pmp_csr_regfile
    import pmp_pkg::*;
#(
    parameter int unsigned NUM_ENTRIES = 4,
    parameter int unsigned PADDR_BITS  = 32
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          csr_wen,
    input  logic                          csr_ren,
    input  logic [11:0]                   csr_addr,
    input  logic [XLEN-1:0]               csr_wdata,
    output logic                          csr_hit,
    output logic                          csr_rvalid,
    output logic [XLEN-1:0]               csr_rdata,
    output logic [NUM_ENTRIES-1:0]        pmp_r,
    output logic [NUM_ENTRIES-1:0]        pmp_w,
    output logic [NUM_ENTRIES-1:0]        pmp_x,
    output logic [NUM_ENTRIES-1:0]        pmp_l,
    output logic [2*NUM_ENTRIES-1:0]      pmp_a,
    output logic [PMP_AW*NUM_ENTRIES-1:0] pmp_addr,
    output logic [XLEN*NUM_ENTRIES-1:0]   pmp_mask,
    output logic                          pmp_update
);

    localparam int unsigned N = NUM_ENTRIES;

    logic              cfg_hit_c;
    logic              addr_hit_c;
    logic [XLEN-1:0]   rdata_c;
    logic [N-1:0]      changed_c;
    pmp_cfg_t          cfg_q  [N];
    logic [PMP_AW-1:0] addr_q [N];

    // CSR window decode: pmpcfg0..3 and pmpaddr0..15.
    assign cfg_hit_c  = (csr_addr[11:2] == PMPCFG_BASE[11:2]);
    assign addr_hit_c = (csr_addr[11:4] == PMPADDR_BASE[11:4]);
    assign csr_hit    = cfg_hit_c | addr_hit_c;

    for (genvar i = 0; i < N; i++) begin : g_entry
        logic next_tor_lock;

        // A locked TOR entry protects the base address held by its predecessor.
        if (i + 1 < N) begin : g_next
            assign next_tor_lock = cfg_q[i+1].l && (cfg_q[i+1].a == A_TOR);
        end else begin : g_last
            assign next_tor_lock = 1'b0;
        end

        pmp_entry #(
            .PADDR_BITS (PADDR_BITS)
        ) u_entry (
            .clock         (clock),
            .reset_n       (reset_n),
            .cfg_we        (csr_wen && cfg_hit_c && (csr_addr[1:0] == 2'(i / 4))),
            .cfg_wdata     (csr_wdata[8*(i%4) +: 8]),
            .addr_we       (csr_wen && addr_hit_c && (csr_addr[3:0] == 4'(i))),
            .addr_wdata    (csr_wdata[PMP_AW-1:0]),
            .next_tor_lock (next_tor_lock),
            .cfg           (cfg_q[i]),
            .addr          (addr_q[i]),
            .mask          (pmp_mask[XLEN*i +: XLEN]),
            .changed_c     (changed_c[i])
        );

        assign pmp_r[i]                     = cfg_q[i].r;
        assign pmp_w[i]                     = cfg_q[i].w;
        assign pmp_x[i]                     = cfg_q[i].x;
        assign pmp_l[i]                     = cfg_q[i].l;
        assign pmp_a[2*i +: 2]              = cfg_q[i].a;
        assign pmp_addr[PMP_AW*i +: PMP_AW] = addr_q[i];
    end

    // Readback mux over current state; unimplemented entries read zero.
    always_comb begin
        rdata_c = '0;
        if (cfg_hit_c) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (csr_addr[1:0] == 2'(i / 4)) begin
                    rdata_c[8*(i%4) +: 8] = cfg_q[i];
                end
            end
        end else if (addr_hit_c) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (csr_addr[3:0] == 4'(i)) begin
                    rdata_c = XLEN'(addr_q[i]);
                end
            end
        end
    end

    // Registered read response and state-change pulse.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            csr_rvalid <= 1'b0;
            csr_rdata  <= '0;
            pmp_update <= 1'b0;
        end else begin
            csr_rvalid <= csr_ren;
            if (csr_ren) begin
                csr_rdata <= rdata_c;
            end
            pmp_update <= |changed_c;
        end
    end

endmodule
